// File: rtl/dht11_responder_if.sv
// -----------------------------------------------------------------------------
// dht11_responder_if
//   Bundle of signals between a DHT11 sensor emulator and its surroundings.
//   The pad and the data bytes are on one side, and the status outputs of the
//   responder are on the other side.
//
//   Signals:
//     dht_in           sampled level of the data line (pad input)
//     dht_drive_low    1 = pull the line low, 0 = release (pull-up)
//     hum_int/hum_dec  humidity bytes offered for transmission
//     temp_int/temp_dec temperature bytes offered for transmission
//     busy             responder is acknowledging / sending a frame
//     frame_done       one-clk pulse when the end-of-frame low is released
//     corrupt_checksum (only with DHT_CHECKSUM_ERR_EN) flip checksum bit 0
//
//   Modports: master = host/pad/data side, slave = responder.
//   Optional macro: DHT_CHECKSUM_ERR_EN
// -----------------------------------------------------------------------------
interface dht11_responder_if;
  logic       dht_in;
  logic       dht_drive_low;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       busy;
  logic       frame_done;

`ifdef DHT_CHECKSUM_ERR_EN
  logic       corrupt_checksum;

  modport master (
    output dht_in, hum_int, hum_dec, temp_int, temp_dec, corrupt_checksum,
    input  dht_drive_low, busy, frame_done
  );

  modport slave (
    input  dht_in, hum_int, hum_dec, temp_int, temp_dec, corrupt_checksum,
    output dht_drive_low, busy, frame_done
  );
`else
  modport master (
    output dht_in, hum_int, hum_dec, temp_int, temp_dec,
    input  dht_drive_low, busy, frame_done
  );

  modport slave (
    input  dht_in, hum_int, hum_dec, temp_int, temp_dec,
    output dht_drive_low, busy, frame_done
  );
`endif
endinterface

// File: rtl/dht11_responder.sv
// -----------------------------------------------------------------------------
// dht11_responder
//   Sensor-side emulation of the DHT11 single-wire protocol. The block waits
//   for a long host low on the data line. After the host releases the line, it
//   acknowledges with 80 us low / 80 us high. It then sends a 40-bit frame
//   {hum_int, hum_dec, temp_int, temp_dec, checksum} MSB first. Each bit is a
//   50 us low followed by a 26 us (0) or 70 us (1) high. The frame ends with a
//   50 us low. All timing is counted in tick_us pulses.
//
//   Ports:
//     clk      system clock
//     rst_n    asynchronous active-low reset (releases the line immediately)
//     tick_us  one-clk pulse every microsecond, the only time base
//     dht      dht11_responder_if.slave (pad level, drive, data bytes, status)
//
//   Optional macro: DHT_CHECKSUM_ERR_EN adds dht.corrupt_checksum. It is
//   sampled with the data snapshot and inverts bit 0 of the sent checksum.
// -----------------------------------------------------------------------------
module dht11_responder #(
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int ACK_US        = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_us,
  dht11_responder_if.slave dht
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_LOW,
    S_RESP_DELAY,
    S_ACK_LOW,
    S_ACK_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  localparam logic [14:0] CNT_MAX    = '1;
  localparam logic [14:0] START_LEN  = 15'(START_MIN_US);
  localparam logic [14:0] RESP_LEN   = 15'(RESP_DELAY_US);
  localparam logic [14:0] ACK_LEN    = 15'(ACK_US);
  localparam logic [14:0] LOW_LEN    = 15'(BIT_LOW_US);
  localparam logic [14:0] HIGH0_LEN  = 15'(BIT0_HIGH_US);
  localparam logic [14:0] HIGH1_LEN  = 15'(BIT1_HIGH_US);
  localparam logic [5:0]  LAST_BIT   = 6'd39;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, line_q;
  logic        line_fall, line_rise;
  logic [14:0] dur_q, dur_inc, phase_len;
  logic        phase_done;
  logic [39:0] shift_q;
  logic [5:0]  bit_cnt_q;
  logic [7:0]  checksum;
  logic        load_snapshot, shift_bit;
  logic        drive_d, drive_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;

  // ---------------------------------------------------------------------------
  // Line synchronizer and edge detect. The flops reset to 1 (idle pull-up
  // level), so no falling edge appears when reset is released.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour (a real shift chain).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync1_q <= dht.dht_in;
      sync2_q <= sync1_q;
      line_q  <= sync2_q;
    end
  end

  assign line_fall =  line_q & ~sync2_q;
  assign line_rise = ~line_q &  sync2_q;

  // ---------------------------------------------------------------------------
  // Saturating microsecond counter, cleared on every state change.
  // dur_inc already includes the tick of the current cycle. This lets a phase
  // end on the clk edge that registers its Nth tick.
  // ---------------------------------------------------------------------------
  assign dur_inc = (tick_us && (dur_q != CNT_MAX)) ? dur_q + 15'd1 : dur_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q <= '0;
    end else if (state_d != state_q) begin
      dur_q <= '0;
    end else begin
      dur_q <= dur_inc;
    end
  end

  always_comb begin
    unique case (state_q)
      S_RESP_DELAY: phase_len = RESP_LEN;
      S_ACK_LOW,
      S_ACK_HIGH:   phase_len = ACK_LEN;
      S_BIT_LOW,
      S_END_LOW:    phase_len = LOW_LEN;
      S_BIT_HIGH:   phase_len = shift_q[39] ? HIGH1_LEN : HIGH0_LEN;
      default:      phase_len = CNT_MAX;
    endcase
  end

  assign phase_done = (dur_inc >= phase_len);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and next-cycle outputs. From ACK_LOW through END_LOW the line
  // is never looked at, so host activity cannot disturb a frame in flight.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement. A path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    load_snapshot = 1'b0;
    shift_bit     = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (line_fall) state_d = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        if (line_rise) begin
          if (dur_inc >= START_LEN) begin
            state_d       = S_RESP_DELAY;
            load_snapshot = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RESP_DELAY: if (phase_done) state_d = S_ACK_LOW;
      S_ACK_LOW:    if (phase_done) state_d = S_ACK_HIGH;
      S_ACK_HIGH:   if (phase_done) state_d = S_BIT_LOW;
      S_BIT_LOW:    if (phase_done) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (phase_done) begin
          shift_bit = 1'b1;
          state_d   = (bit_cnt_q == LAST_BIT) ? S_END_LOW : S_BIT_LOW;
        end
      end
      S_END_LOW: begin
        if (phase_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state and then registered. This
    // keeps the pad drive glitch-free and aligned with the state change.
    drive_d = (state_d == S_ACK_LOW) || (state_d == S_BIT_LOW) ||
              (state_d == S_END_LOW);
    busy_d  = (state_d == S_ACK_LOW)  || (state_d == S_ACK_HIGH) ||
              (state_d == S_BIT_LOW)  || (state_d == S_BIT_HIGH) ||
              (state_d == S_END_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      drive_q <= drive_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot / shift register. The data bytes may change at any time. Only
  // the copy taken when the start request is accepted is ever transmitted.
  // ---------------------------------------------------------------------------
`ifdef DHT_CHECKSUM_ERR_EN
  assign checksum = (dht.hum_int + dht.hum_dec + dht.temp_int + dht.temp_dec)
                    ^ {7'd0, dht.corrupt_checksum};
`else
  assign checksum = dht.hum_int + dht.hum_dec + dht.temp_int + dht.temp_dec;
`endif

  // NOTE: this is a 40-bit register, not a memory array, so it is reset like
  // any other flop to give a defined state out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (load_snapshot) begin
      shift_q   <= {dht.hum_int, dht.hum_dec, dht.temp_int, dht.temp_dec, checksum};
      bit_cnt_q <= '0;
    end else if (shift_bit) begin
      shift_q   <= {shift_q[38:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + 6'd1;
    end
  end

  assign dht.dht_drive_low = drive_q;
  assign dht.busy          = busy_q;
  assign dht.frame_done    = done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// -----------------------------------------------------------------------------
// tb_dht11_responder
//   Self-checking bench for dht11_responder. The line is modelled as a
//   wired-AND of the host and the responder. tick_us is every second clk, and
//   the start threshold is scaled down so that runs stay short. A monitor
//   records every low/high phase of dht_drive_low in microseconds. A reference
//   model builds the expected phase list from the data bytes.
// -----------------------------------------------------------------------------
module tb_dht11_responder;

  localparam int START_MIN    = 300;
  localparam int HOST_LONG_US = 320;
  localparam int HOST_SHORT_US = 200;
  localparam int N_PHASES     = 84;  // resp delay, ack low/high, 40x2 bits, end low
  localparam int TIMEOUT_CLK  = 20000;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic tick_us  = 1'b0;
  logic host_low = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  dht11_responder_if bus();

  assign bus.dht_in = ~(host_low | bus.dht_drive_low);

  dht11_responder #(.START_MIN_US(START_MIN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_us (tick_us),
    .dht     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk); #1 tick_us = 1'b1;
      @(posedge clk); #1 tick_us = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Phase monitor: durations in tick_us pulses between changes of drive_low.
  // ---------------------------------------------------------------------------
  bit  mon_en = 1'b0;
  bit  mon_prev;
  int  mon_ticks;
  int  mon_done_cnt;
  bit  mon_ack_seen;
  bit  mon_busy_at_ack;
  int  mon_dur[$];
  bit  mon_lvl[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.frame_done) mon_done_cnt <= mon_done_cnt + 1;
      if (bus.dht_drive_low != mon_prev) begin
        mon_lvl.push_back(mon_prev);
        mon_dur.push_back(mon_ticks);
        mon_ticks <= tick_us ? 1 : 0;
        mon_prev  <= bus.dht_drive_low;
        if (!mon_ack_seen && bus.dht_drive_low) begin
          mon_ack_seen    <= 1'b1;
          mon_busy_at_ack <= bus.busy;
        end
      end else if (tick_us) begin
        mon_ticks <= mon_ticks + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [39:0] exp_frame;

  function automatic logic [39:0] model_frame(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3,
                                              input bit corrupt);
    int sum;
    int cs;
    sum = int'(b0) + int'(b1) + int'(b2) + int'(b3);
    cs  = sum % 256;
    if (corrupt) cs = cs ^ 1;
    return {b0, b1, b2, b3, 8'(cs)};
  endfunction

  // Expected drive level and length of phase i (i >= 1) of a whole frame.
  function automatic int model_dur(input int i, input logic [39:0] f);
    int k;
    if (i == 1 || i == 2) return 80;
    if (i == N_PHASES - 1) return 50;
    k = (i - 3) / 2;
    if (((i - 3) % 2) == 0) return 50;
    return f[39 - k] ? 70 : 26;
  endfunction

  function automatic bit model_lvl(input int i);
    if (i == 1) return 1'b1;
    if (i == 2) return 1'b0;
    if (i == N_PHASES - 1) return 1'b1;
    return ((i - 3) % 2) == 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input bit corrupt);
    bus.hum_int  = b0;
    bus.hum_dec  = b1;
    bus.temp_int = b2;
    bus.temp_dec = b3;
`ifdef DHT_CHECKSUM_ERR_EN
    bus.corrupt_checksum = corrupt;
`endif
  endtask

  task automatic start_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input bit corrupt);
    set_bytes(b0, b1, b2, b3, corrupt);
    exp_frame = model_frame(b0, b1, b2, b3, corrupt);
    @(negedge clk);
    host_low = 1'b1;
    repeat (2 * HOST_LONG_US) @(negedge clk);
    mon_dur.delete();
    mon_lvl.delete();
    mon_prev        = 1'b0;
    mon_ticks       = 0;
    mon_done_cnt    = 0;
    mon_ack_seen    = 1'b0;
    mon_busy_at_ack = 1'b0;
    host_low        = 1'b0;
    mon_en          = 1'b1;
  endtask

  task automatic wait_phases(input string tag, input int n);
    int i;
    for (i = 0; i < TIMEOUT_CLK && mon_dur.size() < n; i++) @(negedge clk);
    check(tag, 64'(mon_dur.size() >= n), 64'd1);
  endtask

  task automatic finish_frame(input string tag);
    int i;
    logic [39:0] got_bits;
    bit in_range;
    for (i = 0; i < TIMEOUT_CLK && mon_done_cnt == 0; i++) @(negedge clk);
    check({tag, ":frame_done_seen"}, 64'(mon_done_cnt > 0), 64'd1);
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    check({tag, ":done_pulses"}, 64'(mon_done_cnt), 64'd1);
    check({tag, ":busy_at_ack"}, 64'(mon_busy_at_ack), 64'd1);
    check({tag, ":busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, ":drive_after"}, 64'(bus.dht_drive_low), 64'd0);
    check({tag, ":phase_count"}, 64'(mon_dur.size()), 64'(N_PHASES));
    if (mon_dur.size() == N_PHASES) begin
      // Release-to-ack includes up to one tick of synchronizer latency on
      // either side of the 30 us delay.
      in_range = (mon_dur[0] >= 30) && (mon_dur[0] <= 32);
      check($sformatf("%s:resp_delay(%0d)", tag, mon_dur[0]), 64'(in_range), 64'd1);
      got_bits = '0;
      for (int p = 1; p < N_PHASES; p++) begin
        check($sformatf("%s:lvl[%0d]", tag, p), 64'(mon_lvl[p]), 64'(model_lvl(p)));
        check($sformatf("%s:dur[%0d]", tag, p), 64'(mon_dur[p]), 64'(model_dur(p, exp_frame)));
      end
      for (int k = 0; k < 40; k++) got_bits[39 - k] = (mon_dur[4 + 2 * k] > 48);
      check({tag, ":frame_bits"}, 64'(got_bits), 64'(exp_frame));
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input bit corrupt);
    start_frame(b0, b1, b2, b3, corrupt);
    finish_frame(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] r0, r1, r2, r3;
    bit seen_drive, seen_busy;

    set_bytes(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    check("reset:drive", 64'(bus.dht_drive_low), 64'd0);
    check("reset:busy", 64'(bus.busy), 64'd0);
    check("reset:frame_done", 64'(bus.frame_done), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal frame, checksum 0x50.
    run_frame("basic", 8'h37, 8'h00, 8'h19, 8'h00, 1'b0);

    // Too-short host low: no response at all.
    host_low = 1'b1;
    repeat (2 * HOST_SHORT_US) @(negedge clk);
    host_low = 1'b0;
    seen_drive = 1'b0;
    seen_busy  = 1'b0;
    repeat (400) begin
      @(negedge clk);
      seen_drive |= bus.dht_drive_low;
      seen_busy  |= bus.busy;
    end
    check("short:drive", 64'(seen_drive), 64'd0);
    check("short:busy", 64'(seen_busy), 64'd0);

    // Checksum wrap-around: 0xFF+0xFF+0x01+0x02 -> 0x01.
    run_frame("wrap", 8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
`ifdef DHT_CHECKSUM_ERR_EN
    run_frame("corrupt", 8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1);
`endif

    // Inputs change during bit 10; the snapshot must still be sent.
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    start_frame(r0, r1, r2, r3, 1'b0);
    wait_phases("snap:reach_bit10", 23);
    set_bytes(8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0);
    finish_frame("snap");

    // Asynchronous reset during the low phase of bit 20.
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    start_frame(r0, r1, r2, r3, 1'b0);
    wait_phases("rst:reach_bit20", 43);
    repeat (10) @(negedge clk);
    check("rst:in_bit20_low", 64'(bus.dht_drive_low), 64'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst:drive_async", 64'(bus.dht_drive_low), 64'd0);
    check("rst:busy_async", 64'(bus.busy), 64'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    run_frame("after_rst", r0, r1, r2, r3, 1'b0);

    // Host pulls the line low during ACK_HIGH; the frame must be unaffected.
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    start_frame(r0, r1, r2, r3, 1'b0);
    wait_phases("glitch:reach_ack_high", 2);
    repeat (20) @(negedge clk);
    host_low = 1'b1;
    repeat (60) @(negedge clk);
    host_low = 1'b0;
    finish_frame("glitch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Emulates the sensor end of the DHT11 single-wire protocol so the FPGA sensor-query path can be exercised without physical sensors. It detects a host start pulse on the shared data line and answers with the 80 µs/80 µs acknowledge. It then sends a 40-bit frame built from four data bytes plus a checksum. The block sits behind the open-drain pad of one `dht_data` line and uses the shared 1 µs tick from the microsecond generator as its only time base.

## Interface
Parameters:
- `START_MIN_US`, 18000: minimum host low time accepted as a start request.
- `RESP_DELAY_US`, 30: wait after host release before acknowledging.
- `ACK_US`, 80: duration of the acknowledge low phase and of the acknowledge high phase.
- `BIT_LOW_US`, 50: low phase preceding every bit, and the end-of-frame low.
- `BIT0_HIGH_US`, 26: high time encoding a 0 bit.
- `BIT1_HIGH_US`, 70: high time encoding a 1 bit.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: 50 MHz system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `tick_us`, in, 1: one-`clk` pulse every 1 µs.
- `dht_in`, in, 1: sampled level of the data line (pad input).
- `dht_drive_low`, out, 1: 1 means pull the line low; 0 means release it (pull-up).
- `hum_int`, in, 8: humidity integer byte.
- `hum_dec`, in, 8: humidity decimal byte.
- `temp_int`, in, 8: temperature integer byte.
- `temp_dec`, in, 8: temperature decimal byte.
- `busy`, out, 1: high from acknowledge start to frame end.
- `frame_done`, out, 1: one-`clk` pulse when the line is released after the end low.

## Operation
- `dht_in` passes through a 2-flop synchronizer. Edges are detected on the synchronized value.
- Duration counter: 15 bits, advances only on `tick_us`, saturates at 32767, and clears on every state entry.
- States and transitions:
  - IDLE: go to HOST_LOW on a falling edge.
  - HOST_LOW: count while the line is low. On the rising edge, go to RESP_DELAY if count ≥ `START_MIN_US`, otherwise return to IDLE.
  - RESP_DELAY: after `RESP_DELAY_US` ticks, go to ACK_LOW. On entry, snapshot the four bytes and compute the checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, keeping only 8 bits.
  - ACK_LOW: drive low for `ACK_US`, then go to ACK_HIGH.
  - ACK_HIGH: release for `ACK_US`, then go to BIT_LOW.
  - BIT_LOW: drive low for `BIT_LOW_US`, then go to BIT_HIGH.
  - BIT_HIGH: release for `BIT0_HIGH_US` or `BIT1_HIGH_US`, selected by the current bit. Then go to BIT_LOW, or to END_LOW after bit 39.
  - END_LOW: drive low for `BIT_LOW_US`, release, pulse `frame_done`, and return to IDLE.
- Bit order: 40-bit shift register {hum_int, hum_dec, temp_int, temp_dec, checksum}, sent MSB first. A 6-bit bit counter runs 0..39.
- `dht_drive_low` is high only in ACK_LOW, BIT_LOW and END_LOW. It is registered and glitch-free.
- The line level is ignored from ACK_LOW through END_LOW; host activity cannot abort a frame.
- Data inputs may change at any time. Only the snapshot is transmitted.

## Timing
- Reset values: `dht_drive_low`=0, `busy`=0, `frame_done`=0, state=IDLE, all counters 0.
- Reset is asynchronous. Asserting `rst_n` mid-frame releases the line with no `clk` edge needed.
- Edge detection latency: 2–3 `clk` after `dht_in` changes.
- Phase lengths are exact in ticks. A phase of N µs ends on the `clk` after the Nth `tick_us` counted in that phase, giving ±1 µs jitter relative to the tick phase.
- A host low shorter than `START_MIN_US` produces no response. A host low held past saturation is still accepted on release.
- Total response from host release: `RESP_DELAY_US`+160+40×50+Σhigh+50 µs.

## Configuration
- `DHT_CHECKSUM_ERR_EN` defined: adds input `corrupt_checksum` (1 bit), sampled at the snapshot. When it is 1, the transmitted checksum has bit 0 inverted, for exercising reader error handling.
- `DHT_CHECKSUM_ERR_EN` undefined: the port is absent and the checksum is always correct.

## Test plan
- Host low 18 ms then release; bytes 0x37,0x00,0x19,0x00 → after 30 µs: 80 µs low and 80 µs high, then bits of 0x37 0x00 0x19 0x00 0x50, a 50 µs end low, and a single `frame_done` pulse.
- Host low 10 ms then release → `dht_drive_low` stays 0, `busy` stays 0, state returns to IDLE.
- Bytes 0xFF,0xFF,0x01,0x02 → checksum byte 0x01. With the macro defined and `corrupt_checksum`=1 → 0x00. Bit 1 high phases measure 70 µs and bit 0 high phases measure 26 µs.
- Change all data bytes to 0xAA during bit 10 → the remaining bits still match the original snapshot.
- Assert `rst_n` low during BIT_LOW of bit 20 → `dht_drive_low` goes 0 immediately and `busy` goes 0. A fresh 18 ms start after reset yields a complete, correct frame.
- Host pulls the line low during ACK_HIGH → the frame still completes with correct timing and then returns to IDLE.
